// File: rtl/spi_slave_regs_if.sv
// Pin-level and local-port bundle for the SPI register responder.
// The slave modport is the responder side; master is the driving side.
interface spi_slave_regs_if;
  logic       sck_i;
  logic       ncs_i;
  logic       mosi_i;
  logic       miso_o;
  logic       busy;
  logic       ld_we;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  logic       spi_wr;
  logic [5:0] spi_wr_addr;
  logic [7:0] spi_wr_data;

  modport slave (
    input  sck_i, ncs_i, mosi_i, ld_we, ld_addr, ld_data,
    output miso_o, busy, spi_wr, spi_wr_addr, spi_wr_data
  );

  modport master (
    output sck_i, ncs_i, mosi_i, ld_we, ld_addr, ld_data,
    input  miso_o, busy, spi_wr, spi_wr_addr, spi_wr_data
  );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder for the 0x0A write / 0x0B read register protocol,
// backed by a 64-byte register file with a local load port.
module spi_slave_regs #(
  parameter logic [7:0] RO_ID0 = 8'hAD,
  parameter logic [7:0] RO_ID1 = 8'h1D,
  parameter logic [7:0] RO_ID2 = 8'hF2,
  parameter logic [7:0] RO_REV = 8'h01
) (
  input  logic              clk,
  input  logic              reset,
  spi_slave_regs_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_e;

  logic       sck_meta_q, sck_sync_q, sck_hist_q;
  logic       ncs_meta_q, ncs_sync_q, ncs_hist_q;
  logic       mosi_meta_q, mosi_sync_q, mosi_hist_q;
  logic       rise_q, rise_d, fall_q, fall_d;
  logic       busy_q, busy_d;
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       is_read_q, is_read_d;
  logic       reload_q, reload_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic       spi_wr_q, spi_wr_d;
  logic [5:0] spi_wr_addr_q, spi_wr_addr_d;
  logic [7:0] spi_wr_data_q, spi_wr_data_d;
  logic [7:0] regs_q [64];
  logic [7:0] regs_d [64];
  logic [7:0] rd_data;
  logic [7:0] byte_in;
  logic       last_bit;
  logic       commit;

  // ncs chain resets low so a select held low through reset is not seen
  // as a falling edge; a fresh high-to-low transition is required.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_hist_q  <= 1'b0;
      ncs_meta_q  <= 1'b0;
      ncs_sync_q  <= 1'b0;
      ncs_hist_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      mosi_hist_q <= 1'b0;
    end else begin
      sck_meta_q  <= bus.sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_hist_q  <= sck_sync_q;
      ncs_meta_q  <= bus.ncs_i;
      ncs_sync_q  <= ncs_meta_q;
      ncs_hist_q  <= ncs_sync_q;
      mosi_meta_q <= bus.mosi_i;
      mosi_sync_q <= mosi_meta_q;
      mosi_hist_q <= mosi_sync_q;
    end
  end

  always_comb begin
    case (addr_q)
      6'd0:    rd_data = RO_ID0;
      6'd1:    rd_data = RO_ID1;
      6'd2:    rd_data = RO_ID2;
      6'd3:    rd_data = RO_REV;
      default: rd_data = regs_q[addr_q];
    endcase
  end

  always_comb begin
    rise_d        = sck_sync_q & ~sck_hist_q & ~ncs_sync_q;
    fall_d        = ~sck_sync_q & sck_hist_q & ~ncs_sync_q;
    busy_d        = ~ncs_sync_q & (state_q != IDLE);
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    is_read_d     = is_read_q;
    reload_d      = reload_q;
    addr_d        = addr_q;
    tx_d          = tx_q;
    spi_wr_d      = 1'b0;
    spi_wr_addr_d = spi_wr_addr_q;
    spi_wr_data_d = spi_wr_data_q;
    regs_d        = regs_q;
    commit        = 1'b0;
    byte_in       = {shift_q[6:0], mosi_hist_q};
    last_bit      = (bit_cnt_q == 3'd7);

    if (ncs_sync_q) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      is_read_d = 1'b0;
      reload_d  = 1'b0;
      tx_d      = 8'h00;
    end else if (state_q == IDLE) begin
      if (ncs_hist_q) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        shift_d   = 8'h00;
      end
    end else if (rise_q && state_q != IGNORE) begin
      shift_d   = byte_in;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (last_bit) begin
        case (state_q)
          CMD: begin
            if (byte_in == 8'h0A || byte_in == 8'h0B) begin
              state_d   = ADDR;
              is_read_d = (byte_in == 8'h0B);
            end else begin
              state_d = IGNORE;
            end
          end
          ADDR: begin
            addr_d   = byte_in[5:0];
            state_d  = DATA;
            reload_d = is_read_q;
          end
          DATA: begin
            if (is_read_q) begin
              reload_d = 1'b1;
            end else begin
              if (addr_q >= 6'd4) begin
                commit        = 1'b1;
                spi_wr_d      = 1'b1;
                spi_wr_addr_d = addr_q;
                spi_wr_data_d = byte_in;
              end
              addr_d = addr_q + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end else if (fall_q && state_q == DATA && is_read_q) begin
      // The fall after a byte's last rise fetches the next byte; other falls shift.
      if (reload_q) begin
        tx_d     = rd_data;
        addr_d   = addr_q + 6'd1;
        reload_d = 1'b0;
      end else begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end

    // The SPI commit is applied last so it overrides a same-address local write.
    if (bus.ld_we && bus.ld_addr >= 6'd4)
      regs_d[bus.ld_addr] = bus.ld_data;
    if (commit)
      regs_d[addr_q] = byte_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      busy_q        <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      is_read_q     <= 1'b0;
      reload_q      <= 1'b0;
      addr_q        <= 6'd0;
      tx_q          <= 8'h00;
      spi_wr_q      <= 1'b0;
      spi_wr_addr_q <= 6'd0;
      spi_wr_data_q <= 8'h00;
      for (int i = 0; i < 64; i++)
        regs_q[i] <= 8'h00;
    end else begin
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      busy_q        <= busy_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      is_read_q     <= is_read_d;
      reload_q      <= reload_d;
      addr_q        <= addr_d;
      tx_q          <= tx_d;
      spi_wr_q      <= spi_wr_d;
      spi_wr_addr_q <= spi_wr_addr_d;
      spi_wr_data_q <= spi_wr_data_d;
      for (int i = 0; i < 64; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  assign bus.miso_o      = tx_q[7];
  assign bus.busy        = busy_q;
  assign bus.spi_wr      = spi_wr_q;
  assign bus.spi_wr_addr = spi_wr_addr_q;
  assign bus.spi_wr_data = spi_wr_data_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: drives mode-0 SPI transactions and
// local writes, checking MISO bytes, write pulses and reset behaviour.
module tb_spi_slave_regs;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [5:0] wr_addrs [$];
  logic [7:0] wr_datas [$];

  spi_slave_regs_if bus ();

  spi_slave_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Log every committed SPI write so counts and contents can be compared.
  always @(negedge clk) begin
    if (bus.spi_wr === 1'b1) begin
      wr_addrs.push_back(bus.spi_wr_addr);
      wr_datas.push_back(bus.spi_wr_data);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic spi_start();
    bus.sck_i = 1'b0;
    bus.ncs_i = 1'b0;
    #HALF;
  endtask

  task automatic spi_stop();
    #HALF;
    bus.ncs_i = 1'b1;
    #(4 * HALF);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic coll,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.mosi_i = tx[i];
      #HALF;
      rx[i] = bus.miso_o;
      bus.sck_i = 1'b1;
      if (coll && i == 0) begin
        #30;
        bus.ld_we = 1'b1;
        #10;
        bus.ld_we = 1'b0;
        #(HALF - 40);
      end else begin
        #HALF;
      end
      bus.sck_i = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, 1'b0, rx);
  endtask

  task automatic local_write(input logic [5:0] a, input logic [7:0] d);
    bus.ld_addr = a;
    bus.ld_data = d;
    bus.ld_we   = 1'b1;
    #10;
    bus.ld_we   = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    int n0;

    bus.sck_i   = 1'b0;
    bus.ncs_i   = 1'b1;
    bus.mosi_i  = 1'b0;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 6'd0;
    bus.ld_data = 8'h00;
    reset       = 1'b0;
    #40;
    reset = 1'b1;
    #40;

    check("rst_miso", {7'd0, bus.miso_o}, 8'h00);
    check("rst_busy", {7'd0, bus.busy}, 8'h00);
    check("rst_spi_wr", {7'd0, bus.spi_wr}, 8'h00);
    check("rst_wr_addr", {2'd0, bus.spi_wr_addr}, 8'h00);
    check("rst_wr_data", bus.spi_wr_data, 8'h00);

    // Read the four ID bytes
    spi_start();
    check("busy_active", {7'd0, bus.busy}, 8'h01);
    spi_byte(8'h0B, rx); check("id_cmd_miso", rx, 8'h00);
    spi_byte(8'h00, rx); check("id_addr_miso", rx, 8'h00);
    spi_byte(8'h00, rx); check("id0", rx, 8'hAD);
    spi_byte(8'h00, rx); check("id1", rx, 8'h1D);
    spi_byte(8'h00, rx); check("id2", rx, 8'hF2);
    spi_byte(8'h00, rx); check("rev", rx, 8'h01);
    spi_stop();
    check("idle_busy", {7'd0, bus.busy}, 8'h00);
    check("idle_miso", {7'd0, bus.miso_o}, 8'h00);

    // Burst write then read back
    n0 = wr_addrs.size();
    spi_start();
    spi_byte(8'h0A, rx);
    spi_byte(8'h2C, rx);
    spi_byte(8'h13, rx); check("wr_miso_zero", rx, 8'h00);
    spi_byte(8'h5A, rx);
    spi_stop();
    check("burst_wr_count", 8'(wr_addrs.size() - n0), 8'd2);
    check("burst_wr_addr0", {2'd0, wr_addrs[n0]}, 8'h2C);
    check("burst_wr_data0", wr_datas[n0], 8'h13);
    check("burst_wr_addr1", {2'd0, wr_addrs[n0 + 1]}, 8'h2D);
    check("burst_wr_data1", wr_datas[n0 + 1], 8'h5A);
    spi_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h2C, rx);
    spi_byte(8'h00, rx); check("burst_rd0", rx, 8'h13);
    spi_byte(8'h00, rx); check("burst_rd1", rx, 8'h5A);
    spi_stop();

    // Wrap from 0x3F into the read-only ID space
    n0 = wr_addrs.size();
    spi_start();
    spi_byte(8'h0A, rx);
    spi_byte(8'h3F, rx);
    spi_byte(8'h77, rx);
    spi_byte(8'h99, rx);
    spi_stop();
    check("wrap_wr_count", 8'(wr_addrs.size() - n0), 8'd1);
    check("wrap_wr_addr", {2'd0, wr_addrs[n0]}, 8'h3F);
    check("wrap_wr_data", wr_datas[n0], 8'h77);
    spi_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'h00, rx); check("wrap_rd_3f", rx, 8'h77);
    spi_byte(8'h00, rx); check("wrap_rd_00", rx, 8'hAD);
    spi_stop();

    // Abort mid-byte, then an unknown command
    n0 = wr_addrs.size();
    spi_start();
    spi_byte(8'h0A, rx);
    spi_byte(8'h10, rx);
    spi_bits(8'hFF, 5, 1'b0, rx);
    spi_stop();
    spi_start();
    spi_byte(8'h0D, rx); check("badcmd_miso0", rx, 8'h00);
    spi_byte(8'h10, rx); check("badcmd_miso1", rx, 8'h00);
    spi_byte(8'h55, rx); check("badcmd_miso2", rx, 8'h00);
    spi_stop();
    check("abort_wr_count", 8'(wr_addrs.size() - n0), 8'd0);
    spi_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h00, rx); check("abort_rd_10", rx, 8'h00);
    spi_stop();

    // Local write colliding with an SPI commit to the same address
    n0 = wr_addrs.size();
    bus.ld_addr = 6'h08;
    bus.ld_data = 8'h11;
    spi_start();
    spi_byte(8'h0A, rx);
    spi_byte(8'h08, rx);
    spi_bits(8'h22, 8, 1'b1, rx);
    spi_stop();
    check("coll_wr_count", 8'(wr_addrs.size() - n0), 8'd1);
    check("coll_wr_data", wr_datas[n0], 8'h22);
    spi_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h08, rx);
    spi_byte(8'h00, rx); check("coll_rd_08", rx, 8'h22);
    spi_stop();

    // Local writes: RO address ignored, mid-transaction write visible
    local_write(6'h01, 8'hEE);
    spi_start();
    spi_byte(8'h0B, rx);
    local_write(6'h09, 8'h33);
    spi_byte(8'h09, rx);
    spi_byte(8'h00, rx); check("local_rd_09", rx, 8'h33);
    spi_stop();
    spi_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h00, rx); check("local_ro_01", rx, 8'h1D);
    spi_stop();

    // Reset during the second data byte of a read
    spi_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx); check("rstmid_id0", rx, 8'hAD);
    spi_bits(8'h00, 4, 1'b0, rx); check("rstmid_partial", rx, 8'h10);
    #HALF;
    check("rstmid_miso_pre", {7'd0, bus.miso_o}, 8'h01);
    reset = 1'b0;
    #1;
    check("rstmid_miso", {7'd0, bus.miso_o}, 8'h00);
    check("rstmid_busy", {7'd0, bus.busy}, 8'h00);
    #19;
    reset = 1'b1;
    bus.ncs_i = 1'b1;
    #(4 * HALF);
    spi_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx); check("post_rst_id0", rx, 8'hAD);
    spi_byte(8'h00, rx); check("post_rst_id1", rx, 8'h1D);
    spi_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI mode-0 responder implementing the accelerometer register protocol our `pb_spi` master issues: 0x0A write, 0x0B read, with auto-incrementing address. It holds a 64-byte register file, and a local load port lets sensor-side logic inject sample data. It sits on the far end of the `sck_o`/`ncs_o`/`mosi_o`/`miso_i` link. Uses are loopback on the FPGA and a synthesizable accelerometer stand-in in SoC benches.

## Interface
- `RO_ID0`, default 8'hAD, read-only value at address 0x00
- `RO_ID1`, default 8'h1D, read-only value at address 0x01
- `RO_ID2`, default 8'hF2, read-only value at address 0x02
- `RO_REV`, default 8'h01, read-only value at address 0x03
- `clk` in 1: system clock; must be at least 8× the SCK frequency.
- `reset` in 1: asynchronous, active-low reset.
- `sck_i` in 1: SPI clock from master; asynchronous.
- `ncs_i` in 1: chip select, active-low; asynchronous.
- `mosi_i` in 1: master-out data; asynchronous.
- `miso_o` out 1: slave-out data, MSB first.
- `busy` out 1: high while a transaction is in progress (synchronized `ncs_i` low).
- `ld_we` in 1: local write strobe.
- `ld_addr` in 6: local write address.
- `ld_data` in 8: local write data.
- `spi_wr` out 1: one-cycle pulse when an SPI write commits.
- `spi_wr_addr` out 6: address of the committed SPI write; valid with `spi_wr`.
- `spi_wr_data` out 8: data of the committed SPI write; valid with `spi_wr`.

## Operation
**Input synchronization**
- `sck_i`, `ncs_i` and `mosi_i` each pass through a 2-flop synchronizer and then one history flop.
- `rise`/`fall` are single-cycle edge pulses of synchronized SCK, qualified by synchronized ncs being low.

**States**
- `IDLE → CMD`: on synchronized ncs falling.
- `CMD → ADDR`: after 8 rises, if cmd = 0x0A or 0x0B.
- `CMD → IGNORE`: after 8 rises, for any other cmd.
- `ADDR → DATA`: after 8 rises.
- `DATA`: loops per byte.
- Any state `→ IDLE`: on synchronized ncs high.

**Bit handling**
- A 3-bit counter counts rises; it clears on entering CMD and on every byte boundary.
- MOSI is shifted in on `rise`, MSB first.

**Address handling**
- Address bits [7:6] are ignored; only [5:0] are used.
- The address increments after each data byte, wrapping 0x3F → 0x00.

**Write (0x0A)**
- On the 8th rise of each data byte, commit to `reg[addr]` and pulse `spi_wr`, then increment addr.
- Writes to 0x00–0x03 are dropped: no commit, no `spi_wr`, but the address still increments.

**Read (0x0B)**
- On the `fall` following the 8th address rise, load the TX shift register with `reg[addr]`, then increment addr.
- Each `fall` within a byte shifts the TX register left; `miso_o` is the TX register MSB.
- On the `fall` after each data byte's 8th rise, reload the TX register from the current addr and increment addr.

**MISO during other phases**
- `miso_o` = 0 in IDLE, CMD, ADDR, IGNORE and write transactions.

**Local port**
- `ld_we` writes `ld_data` to `reg[ld_addr]` on the next edge.
- RO addresses ignore local writes.
- If an SPI commit and `ld_we` target the same address in the same cycle, SPI wins and the local write is dropped.
- Local writes are allowed during transactions. A read byte already loaded into the TX register is not affected.

**Abort**
- ncs deasserting mid-byte discards the partial byte with no commit.
- The state machine, bit counter and shifters return to IDLE values.

## Timing
- Reset values:
  - `miso_o` = 0, `busy` = 0, `spi_wr` = 0, `spi_wr_addr` = 0, `spi_wr_data` = 0.
  - State IDLE; registers 0x04–0x3F = 0x00.
  - RO registers are constants.
- Pad-to-edge-pulse latency is 3 clk cycles.
- An SPI commit, with `spi_wr` high, occurs 1 cycle after the `rise` pulse of bit 8.
- `miso_o` updates 1 cycle after the `fall` pulse, i.e. 4 clk after the SCK pad falling edge. This is well before the next rise at ≥8 clk per SCK period.
- The first read bit is valid before the first data-byte rise.
- `busy` follows synchronized ncs with 2 clk latency.
- A local write is visible to SPI reads loaded in any later cycle.
- Reset asserted mid-transaction forces all reset values immediately. A new transaction requires a fresh ncs falling edge after reset releases.

## Test plan
- **Read IDs:** ncs low, 0x0B, 0x00, 4 dummy bytes → MISO returns 0xAD, 0x1D, 0xF2, 0x01.
- **Burst write then read:** 0x0A, 0x2C, 0x13, 0x5A, then read 0x0B, 0x2C, 2 bytes → MISO returns 0x13, 0x5A; `spi_wr` pulses twice with addr 0x2C/0x2D.
- **Wrap and RO protect:** write 0x0A, 0x3F, 0x77, 0x99 → reg 0x3F = 0x77; address 0x00 still reads 0xAD; only one `spi_wr`.
- **Abort and bad command:** ncs high after 5 data bits of a write to 0x10 → reg 0x10 unchanged, no `spi_wr`. Command 0x0D → MISO stays 0, no register changes.
- **Local/SPI collision:** `ld_we` to 0x08 with 0x11 in the same cycle as an SPI commit of 0x22 to 0x08 → reg 0x08 = 0x22. A local write of 0x33 to 0x09 during a transaction reads back as 0x33.
- **Reset mid-read:** reset low during the second data byte → `miso_o` = 0 and `busy` = 0 at once. A following transaction reads IDs correctly.
